// File: rtl/response_compactor_pkg.sv
// Shared types and constants for the response compactor (MISR-based signature analyser).
package response_compactor_pkg;

    localparam int OBS_W_DEF = 5;
    localparam int SIG_W_DEF = 16;
    localparam int CNT_W_DEF = 10;

    localparam logic [15:0] MISR_POLY = 16'h1021;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/response_compactor_misr_step.sv
// One MISR step: shift left, fold the polynomial in on MSB carry-out, XOR the response in.
module misr_step #(
    parameter int               SIG_W = 16,
    parameter int               OBS_W = 5,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021
) (
    input  logic [SIG_W-1:0] sig_i,
    input  logic [OBS_W-1:0] obs_i,
    output logic [SIG_W-1:0] sig_o
);

    logic [SIG_W-1:0] shifted;
    logic [SIG_W-1:0] fb;
    logic [SIG_W-1:0] obs_ext;

    always_comb begin
        shifted = {sig_i[SIG_W-2:0], 1'b0};
        fb      = sig_i[SIG_W-1] ? POLY : '0;
        obs_ext = '0;
        obs_ext[OBS_W-1:0] = obs_i;
        sig_o   = shifted ^ fb ^ obs_ext;
    end

endmodule

// File: rtl/response_compactor.sv
// Session FSM and pattern counter around a MISR that compacts circuit responses into a signature.
module response_compactor
    import response_compactor_pkg::*;
#(
    parameter int OBS_W = OBS_W_DEF,
    parameter int SIG_W = SIG_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [SIG_W-1:0] expected_sig,
    input  logic             obs_valid,
    input  logic [OBS_W-1:0] obs_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] pattern_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q;
    logic             busy_q;
    logic             done_q;
    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] num_q;

    misr_step #(
        .SIG_W (SIG_W),
        .OBS_W (OBS_W),
        .POLY  (SIG_W'(MISR_POLY))
    ) u_misr (
        .sig_i (sig_q),
        .obs_i (obs_data),
        .sig_o (sig_d)
    );

    assign cnt_d = cnt_q + CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sig_q   <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        num_q <= num_patterns;
                        sig_q <= '0;
                        cnt_q <= '0;
                        if (num_patterns == '0) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        sig_q   <= '0;
                        cnt_q   <= '0;
                    end else if (obs_valid) begin
                        sig_q <= sig_d;
                        cnt_q <= cnt_d;
                        // Counter stops at num_q, so it can never wrap.
                        if (cnt_d == num_q) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        sig_q   <= '0;
                        cnt_q   <= '0;
                    end else if (start) begin
                        num_q <= num_patterns;
                        sig_q <= '0;
                        cnt_q <= '0;
                        if (num_patterns == '0) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign signature     = sig_q;
    assign pattern_count = cnt_q;
    // Golden value may change while in DONE, so compare against it live.
    assign pass          = done_q && (sig_q == expected_sig);

endmodule

// File: tb/tb_response_compactor.sv
// Directed self-checking bench for response_compactor.
module tb_response_compactor;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [9:0]  num_patterns;
    logic [15:0] expected_sig;
    logic        obs_valid;
    logic [4:0]  obs_data;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;
    logic [9:0]  pattern_count;

    int n_chk;
    int n_err;

    response_compactor dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .num_patterns  (num_patterns),
        .expected_sig  (expected_sig),
        .obs_valid     (obs_valid),
        .obs_data      (obs_data),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .signature     (signature),
        .pattern_count (pattern_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        num_patterns = '0;
        expected_sig = '0;
        obs_valid = 1'b0;
        obs_data = '0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_sig",  32'(signature), 32'd0);
        chk("rst_cnt",  32'(pattern_count), 32'd0);
        rst_n = 1'b1;
        step();

        // Single pattern
        num_patterns = 10'd1; expected_sig = 16'h0001; start = 1'b1;
        step();
        start = 1'b0;
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_done_early", 32'(done), 32'd0);
        obs_valid = 1'b1; obs_data = 5'b00001;
        step();
        obs_valid = 1'b0; obs_data = 5'b00000;
        chk("t1_sig",  32'(signature), 32'h0001);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_cnt",  32'(pattern_count), 32'd1);

        // 17 patterns, restart directly from DONE
        num_patterns = 10'd17; expected_sig = 16'h1020; start = 1'b1;
        step();
        start = 1'b0;
        chk("t2_sig_clr", 32'(signature), 32'd0);
        chk("t2_cnt_clr", 32'(pattern_count), 32'd0);
        chk("t2_busy", 32'(busy), 32'd1);
        obs_valid = 1'b1; obs_data = 5'b00001;
        step();
        obs_data = 5'b00000;
        for (int i = 0; i < 15; i++) step();
        chk("t2_sig16", 32'(signature), 32'h8000);
        chk("t2_cnt16", 32'(pattern_count), 32'd16);
        chk("t2_done16", 32'(done), 32'd0);
        step();
        obs_valid = 1'b0;
        chk("t2_sig",  32'(signature), 32'h1021);
        chk("t2_cnt",  32'(pattern_count), 32'd17);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_pass_bad", 32'(pass), 32'd0);
        expected_sig = 16'h1021;
        #1;
        chk("t2_pass_live", 32'(pass), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t2_abort_done", 32'(done), 32'd0);
        chk("t2_abort_sig", 32'(signature), 32'd0);

        // Gapped valids, start in RUN ignored, valid in DONE ignored
        num_patterns = 10'd4; expected_sig = 16'h000F; start = 1'b1;
        step();
        start = 1'b0;
        obs_data = 5'b00001;
        for (int i = 0; i < 7; i++) begin
            obs_valid = (i % 2 == 0);
            start = (i == 3);
            num_patterns = (i == 3) ? 10'd1 : 10'd4;
            step();
            if (i == 3) chk("t3_start_ign", 32'(signature), 32'h0003);
            if (i == 5) chk("t3_done_early", 32'(done), 32'd0);
        end
        start = 1'b0; obs_valid = 1'b0;
        chk("t3_sig",  32'(signature), 32'h000F);
        chk("t3_cnt",  32'(pattern_count), 32'd4);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_pass", 32'(pass), 32'd1);
        obs_valid = 1'b1;
        step();
        obs_valid = 1'b0;
        chk("t3_extra_sig", 32'(signature), 32'h000F);
        chk("t3_extra_cnt", 32'(pattern_count), 32'd4);

        // Zero patterns
        num_patterns = 10'd0; expected_sig = 16'h0000; start = 1'b1;
        step();
        start = 1'b0;
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_sig",  32'(signature), 32'd0);
        chk("t4_pass", 32'(pass), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        obs_valid = 1'b1; obs_data = 5'b10101;
        step();
        obs_valid = 1'b0;
        chk("t4_idle_obs", 32'(signature), 32'd0);
        chk("t4_idle_done", 32'(done), 32'd0);

        // Abort with obs_valid, then async reset mid-RUN
        num_patterns = 10'd10; start = 1'b1;
        step();
        start = 1'b0;
        obs_valid = 1'b1; obs_data = 5'b00001;
        step();
        step();
        chk("t5_sig_pre", 32'(signature), 32'h0003);
        abort = 1'b1;
        step();
        abort = 1'b0; obs_valid = 1'b0;
        chk("t5_abort_busy", 32'(busy), 32'd0);
        chk("t5_abort_sig",  32'(signature), 32'd0);
        chk("t5_abort_cnt",  32'(pattern_count), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        obs_valid = 1'b1;
        step();
        obs_valid = 1'b0;
        chk("t5_run_sig", 32'(signature), 32'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_sig",  32'(signature), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_cnt",  32'(pattern_count), 32'd0);
        rst_n = 1'b1;
        obs_valid = 1'b1;
        step();
        step();
        obs_valid = 1'b0;
        chk("t5_idle_busy", 32'(busy), 32'd0);
        chk("t5_idle_sig",  32'(signature), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/response_compactor.md
RESPONSE_COMPACTOR -- requirements
Module: response_compactor

Interface
REQ-001 Parameter OBS_W, 5, width of the observed response bus (one bit per circuit output: t, n, r, k, m, LSB first).
REQ-002 Parameter SIG_W, 16, signature register width.
REQ-003 Parameter CNT_W, 10, pattern counter width.
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 Port start  input  1  begin a compaction session (sampled high for one or more cycles).
REQ-007 Port abort  input  1  cancel a session in progress.
REQ-008 Port num_patterns  input  CNT_W  number of responses to compact, latched on accepted start.
REQ-009 Port expected_sig  input  SIG_W  golden signature, compared in DONE.
REQ-010 Port obs_valid  input  1  obs_data holds a valid response this cycle.
REQ-011 Port obs_data  input  OBS_W  response vector from the circuit under test.
REQ-012 Port busy  output  1  high in RUN.
REQ-013 Port done  output  1  high in DONE.
REQ-014 Port pass  output  1  high in DONE only when signature equals expected_sig.
REQ-015 Port signature  output  SIG_W  current MISR contents.
REQ-016 Port pattern_count  output  CNT_W  responses compacted in the current/last session.

Function
REQ-017 FSM states IDLE, RUN, DONE; all outputs registered.
REQ-018 IDLE + start: latch num_patterns, clear signature to 0, clear pattern_count to 0, go to RUN (or directly to DONE if num_patterns == 0).
REQ-019 RUN + obs_valid: signature_next = (signature << 1) XOR (signature[SIG_W-1] ? 16'h1021 : 0) XOR zero-extended obs_data; pattern_count increments by 1.
REQ-020 RUN + !obs_valid: signature and pattern_count hold.
REQ-021 RUN: when the accepted response makes pattern_count equal the latched num_patterns, go to DONE the same edge; done rises the cycle after the last response is sampled.
REQ-022 obs_valid outside RUN, and obs_valid after the final pattern, are ignored.
REQ-023 pass = done AND (signature == expected_sig), evaluated continuously in DONE against the current expected_sig.
REQ-024 DONE holds signature, pattern_count, done until start (new session, per REQ-018) or abort (to IDLE).
REQ-025 start in RUN is ignored.
REQ-026 abort in RUN or DONE: go to IDLE next edge, signature and pattern_count cleared to 0; abort has priority over start and obs_valid in the same cycle.
REQ-027 pattern_count never wraps; num_patterns max 2^CNT_W-1.

Reset
REQ-028 rst_n low forces IDLE, busy=0, done=0, pass=0, signature=0, pattern_count=0 immediately, regardless of clk.
REQ-029 Reset asserted mid-RUN discards the session; after release the block waits in IDLE for start.

Structure
REQ-030 Shared package response_compactor_pkg holds the state enum, MISR polynomial constant 16'h1021, and default widths.
REQ-031 The MISR next-state is a separate sub-module misr_step (combinational, parameterised by SIG_W, OBS_W, polynomial); FSM and counter stay in response_compactor.

Verification
REQ-032 num_patterns=1, obs_data=5'b00001 valid one cycle -> signature 16'h0001, done=1 next cycle, pass=1 with expected_sig=16'h0001.
REQ-033 num_patterns=17, obs 5'b00001 then 16 x 5'b00000 -> signature 16'h1021 (after 16 patterns 16'h8000), pattern_count=17; expected_sig=16'h1020 -> pass=0.
REQ-034 num_patterns=4 with obs_valid toggled 1,0,1,0,1,0,1 (obs=5'b00001) -> signature 16'h000F, done only after 4th valid; extra valid in DONE leaves signature unchanged.
REQ-035 num_patterns=0, start -> DONE next cycle, signature 16'h0000, pass=1 with expected_sig=0.
REQ-036 abort and obs_valid together mid-RUN -> IDLE, signature 0, pattern_count 0; rst_n pulse low mid-RUN between clock edges -> outputs zero immediately, IDLE after release.
